eeg_window_feature: RTL and testbench

//  Downstream consumer of the band-pass filter sample stream (32-bit signed, Q27 scaling).

---
 rtl/eeg_feat_pkg.sv | 19 +
 rtl/eeg_window_feature_if.sv | 28 ++
 rtl/sat_acc.sv | 51 +++++
 rtl/eeg_window_feature.sv | 112 +++++++++++
 tb/tb_eeg_window_feature.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eeg_feat_pkg.sv
// Shared definitions for the EEG feature-extraction chain: default widths, FSM encoding
// and the fixed-point scaling used by the filter stages feeding this block.
package eeg_feat_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ACC_W  = 72;

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  // Samples arrive as Q27: 1.0 == 2^27.
  localparam int unsigned Q_FRAC_W = 27;

  typedef enum logic {
    StAccum = ST_ACCUM,
    StHold  = ST_HOLD
  } state_e;

endpackage

// File: rtl/eeg_window_feature_if.sv
// Sample stream in (valid/ready) and per-window feature result out (valid/ready).
interface eeg_window_feature_if
  import eeg_feat_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
);

  logic                     s_valid;
  logic signed [DATA_W-1:0] s_data;
  logic                     s_ready;
  logic                     m_valid;
  logic                     m_ready;
  logic [ACC_W-1:0]         m_line_len;
  logic [ACC_W-1:0]         m_energy;
  logic                     m_sat;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_line_len, m_energy, m_sat
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_line_len, m_energy, m_sat
  );

endinterface

// File: rtl/sat_acc.sv
// Unsigned saturating accumulator with a sticky saturation flag; clr has priority over en.
module sat_acc #(
  parameter int unsigned IN_W  = 33,
  parameter int unsigned ACC_W = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [ACC_W-1:0] acc,
  output logic             sat
);

  // One bit wider than the larger operand, so the carry out is never lost.
  localparam int unsigned SUM_W = ((IN_W > ACC_W) ? IN_W : ACC_W) + 1;

  logic [SUM_W-1:0] sum;
  logic             over;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;

  assign sum  = SUM_W'(acc_q) + SUM_W'(in);
  assign over = |sum[SUM_W-1:ACC_W];

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (en) begin
      acc_d = over ? '1 : sum[ACC_W-1:0];
      sat_d = sat_q | over;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc = acc_q;
  assign sat = sat_q;

endmodule

// File: rtl/eeg_window_feature.sv
// Line length and energy over non-overlapping windows of WIN_LEN samples; one result per
// window is held on the output handshake while the input is stalled.
module eeg_window_feature
  import eeg_feat_pkg::*;
#(
  parameter int unsigned  DATA_W  = DEF_DATA_W,
  parameter int unsigned  WIN_LEN = 256,
  parameter int unsigned  ACC_W   = DEF_ACC_W,
  localparam int unsigned CNT_W   = $clog2(WIN_LEN)
) (
  input logic                 clk,
  input logic                 reset,
  eeg_window_feature_if.slave bus
);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] x_prev_q;
  logic                     prev_ok_q;
  logic                     accept, win_end, handoff;
  logic signed [DATA_W:0]   diff;
  logic [DATA_W:0]          abs_diff, ll_in;
  logic [2*DATA_W-1:0]      x_ext, sq;
  logic                     ll_sat, en_sat;

  assign accept  = bus.s_valid & bus.s_ready;
  assign handoff = bus.m_valid & bus.m_ready;
  assign win_end = accept && (cnt_q == CNT_W'(WIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= StAccum;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (win_end) state_d = StHold;
      StHold:  if (handoff) state_d = StAccum;
      default: state_d = StAccum;
    endcase
  end

  // Handshake flags depend on state only, so the handoff cycle never takes a sample.
  always_comb begin
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    unique case (state_q)
      StAccum: bus.s_ready = 1'b1;
      StHold:  bus.m_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (handoff)     cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;
  end

  // x_prev/prev_ok survive the window boundary; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      x_prev_q  <= '0;
      prev_ok_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        x_prev_q  <= bus.s_data;
        prev_ok_q <= 1'b1;
      end
    end
  end

  always_comb begin
    diff     = {bus.s_data[DATA_W-1], bus.s_data} - {x_prev_q[DATA_W-1], x_prev_q};
    abs_diff = diff[DATA_W] ? unsigned'(-diff) : unsigned'(diff);
    ll_in    = prev_ok_q ? abs_diff : '0;
    x_ext    = {{DATA_W{bus.s_data[DATA_W-1]}}, bus.s_data};
    sq       = x_ext * x_ext;
  end

  sat_acc #(
    .IN_W  (DATA_W + 1),
    .ACC_W (ACC_W)
  ) u_line_len (
    .clk   (clk),
    .reset (reset),
    .clr   (handoff),
    .en    (accept),
    .in    (ll_in),
    .acc   (bus.m_line_len),
    .sat   (ll_sat)
  );

  sat_acc #(
    .IN_W  (2 * DATA_W),
    .ACC_W (ACC_W)
  ) u_energy (
    .clk   (clk),
    .reset (reset),
    .clr   (handoff),
    .en    (accept),
    .in    (sq),
    .acc   (bus.m_energy),
    .sat   (en_sat)
  );

  assign bus.m_sat = ll_sat | en_sat;

endmodule

// File: tb/tb_eeg_window_feature.sv
// Bench for eeg_window_feature: a window-level reference model on the WIN_LEN=4 instance,
// a vector table of whole windows, hold/reset corner sequences and a saturating instance.
module tb_eeg_window_feature;

  localparam int unsigned WIN_A = 4;
  localparam int unsigned ACC_A = 72;
  localparam int unsigned WIN_B = 8;
  localparam int unsigned ACC_B = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  eeg_window_feature_if #(.DATA_W(32), .ACC_W(ACC_A)) a_if ();
  eeg_window_feature_if #(.DATA_W(32), .ACC_W(ACC_B)) b_if ();

  eeg_window_feature #(.DATA_W(32), .WIN_LEN(WIN_A), .ACC_W(ACC_A)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (a_if.slave)
  );

  eeg_window_feature #(.DATA_W(32), .WIN_LEN(WIN_B), .ACC_W(ACC_B)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (b_if.slave)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (window level) ----------------
  typedef struct {
    logic [ACC_A-1:0] ll;
    logic [ACC_A-1:0] en;
    bit               sat;
  } res_t;

  res_t              exp_q[$];
  logic signed [31:0] win_q[$];
  logic signed [31:0] m_prev;
  bit                 m_prev_ok;
  int                 rx_cnt = 0;

  function automatic res_t golden(input logic signed [31:0] xs[$], input logic signed [31:0] prev,
                                  input bit ok);
    logic [127:0]       ll = '0;
    logic [127:0]       en = '0;
    logic [127:0]       mx;
    logic signed [31:0] p;
    longint             d;
    res_t               r;
    mx = (128'd1 << ACC_A) - 128'd1;
    p  = prev;
    foreach (xs[i]) begin
      d = longint'(xs[i]) - longint'(p);
      if (i > 0 || ok) ll += 128'(d < 0 ? -d : d);
      en += 128'(longint'(xs[i]) * longint'(xs[i]));
      p = xs[i];
    end
    r.sat = (ll > mx) || (en > mx);
    r.ll  = ACC_A'(ll > mx ? mx : ll);
    r.en  = ACC_A'(en > mx ? mx : en);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      win_q.delete();
      exp_q.delete();
      m_prev    = '0;
      m_prev_ok = 1'b0;
    end else begin
      check("mon_m_valid", a_if.m_valid, exp_q.size() != 0);
      check("mon_s_ready", a_if.s_ready, exp_q.size() == 0);
      if (exp_q.size() != 0) begin
        check("mon_line_len", a_if.m_line_len, exp_q[0].ll);
        check("mon_energy", a_if.m_energy, exp_q[0].en);
        check("mon_sat", a_if.m_sat, exp_q[0].sat);
        if (a_if.m_ready) begin
          void'(exp_q.pop_front());
          rx_cnt++;
        end
      end
      if (a_if.s_valid && a_if.s_ready) begin
        win_q.push_back(a_if.s_data);
        if (win_q.size() == WIN_A) begin
          exp_q.push_back(golden(win_q, m_prev, m_prev_ok));
          m_prev    = win_q[$];
          m_prev_ok = 1'b1;
          win_q.delete();
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc_a(input bit v, input logic [31:0] d, input bit mr, output bit acc,
                       output bit mv);
    a_if.s_valid = v;
    a_if.s_data  = d;
    a_if.m_ready = mr;
    @(negedge clk);
    acc = v && a_if.s_ready;
    mv  = a_if.m_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input bit v, input logic [31:0] d, input bit mr, output bit acc,
                       output bit mv);
    b_if.s_valid = v;
    b_if.s_data  = d;
    b_if.m_ready = mr;
    @(negedge clk);
    acc = v && b_if.s_ready;
    mv  = b_if.m_valid;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_sample();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return $urandom_range(0, 200) - 100;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    bit               rst_first;
    logic [31:0]      p0, p1;
    logic [3:0][31:0] s;
    logic [71:0]      ll, en;
    bit               sat;
  } vec_t;

  function automatic vec_t mk(input bit r, input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] d, input logic [71:0] ll, input logic [71:0] en,
                              input bit sat);
    vec_t v;
    v.rst_first = r;
    v.p0 = p0;
    v.p1 = p1;
    v.s[0] = a;
    v.s[1] = b;
    v.s[2] = c;
    v.s[3] = d;
    v.ll = ll;
    v.en = en;
    v.sat = sat;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[5];
    bit          acc, mv;
    bit          have;
    int          sent, base_rx;
    logic [31:0] cur;

    vt[0] = mk(0, 0, 0, 0, 10, -10, 5, 72'd45, 72'd225, 0);
    vt[1] = mk(0, 0, 0, 5, 5, 5, 5, 72'd0, 72'd100, 0);
    vt[2] = mk(0, 0, 0, -3, 100, 0, -100, 72'd311, 72'd20009, 0);
    vt[3] = mk(1, 3, 7, 1, 2, 3, 4, 72'd3, 72'd30, 0);
    vt[4] = mk(0, 0, 0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
               72'd2147483643 + 72'd3 * 72'd4294967295,
               72'd2 * (72'd4611686014132420609 + 72'd4611686018427387904), 0);

    a_if.s_valid = 1'b0; a_if.s_data = '0; a_if.m_ready = 1'b0;
    b_if.s_valid = 1'b0; b_if.s_data = '0; b_if.m_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_valid", a_if.m_valid, 0);
    check("reset_s_ready", a_if.s_ready, 1);
    check("reset_line_len", a_if.m_line_len, 0);
    check("reset_energy", a_if.m_energy, 0);
    check("reset_sat", a_if.m_sat, 0);
    check("reset_b_m_valid", b_if.m_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Whole windows back-to-back with m_ready held high.
    for (int k = 0; k < 5; k++) begin
      if (vt[k].rst_first) begin
        cyc_a(1, vt[k].p0, 1, acc, mv);
        cyc_a(1, vt[k].p1, 1, acc, mv);
        rst = 1'b1;
        cyc_a(0, 0, 1, acc, mv);
        rst = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        cyc_a(1, vt[k].s[i], 1, acc, mv);
        check($sformatf("v%0d_accept%0d", k, i), acc, 1);
        check($sformatf("v%0d_early_valid%0d", k, i), mv, 0);
      end
      a_if.s_valid = 1'b0;
      a_if.m_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_m_valid", k), a_if.m_valid, 1);
      check($sformatf("v%0d_line_len", k), a_if.m_line_len, vt[k].ll);
      check($sformatf("v%0d_energy", k), a_if.m_energy, vt[k].en);
      check($sformatf("v%0d_sat", k), a_if.m_sat, vt[k].sat);
      @(posedge clk);
      #1;
      cyc_a(0, 0, 1, acc, mv);
      check($sformatf("v%0d_valid_one_clk", k), mv, 0);
    end

    // Result held for 10 cycles with a sample waiting upstream.
    for (int i = 1; i <= 4; i++) cyc_a(1, i, 0, acc, mv);
    for (int i = 0; i < 10; i++) begin
      cyc_a(1, 99, 0, acc, mv);
      check("hold_no_accept", acc, 0);
      check("hold_m_valid", mv, 1);
    end
    cyc_a(1, 99, 1, acc, mv);
    check("handoff_no_accept", acc, 0);
    cyc_a(1, 99, 1, acc, mv);
    check("after_hold_accept", acc, 1);
    for (int i = 0; i < 3; i++) cyc_a(1, 0, 1, acc, mv);
    a_if.s_valid = 1'b0;
    @(negedge clk);
    check("after_hold_line_len", a_if.m_line_len, 194);
    check("after_hold_energy", a_if.m_energy, 9801);
    @(posedge clk);
    #1;

    // Saturating instance: full-scale alternation clamps, next window is clean.
    for (int i = 0; i < WIN_B; i++) cyc_b(1, (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000, 1,
                                          acc, mv);
    b_if.s_valid = 1'b0;
    @(negedge clk);
    check("sat_m_valid", b_if.m_valid, 1);
    check("sat_line_len", b_if.m_line_len, (128'd1 << ACC_B) - 1);
    check("sat_energy", b_if.m_energy, (128'd1 << ACC_B) - 1);
    check("sat_flag", b_if.m_sat, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < WIN_B; i++) cyc_b(1, 1, 1, acc, mv);
    b_if.s_valid = 1'b0;
    @(negedge clk);
    check("unsat_m_valid", b_if.m_valid, 1);
    check("unsat_line_len", b_if.m_line_len, 128'd2147483649);
    check("unsat_energy", b_if.m_energy, 8);
    check("unsat_flag", b_if.m_sat, 0);
    @(posedge clk);
    #1;
    b_if.m_ready = 1'b0;

    // Random gaps on both sides; the monitor compares every result against the model.
    base_rx = rx_cnt;
    sent    = 0;
    have    = 1'b0;
    cur     = '0;
    for (int c = 0; c < 60000 && rx_cnt < base_rx + 1000; c++) begin
      if (!have && sent < 4000) begin
        cur  = rnd_sample();
        have = 1'b1;
      end
      cyc_a(have && ($urandom_range(0, 3) != 0), cur, $urandom_range(0, 2) != 0, acc, mv);
      if (acc) begin
        have = 1'b0;
        sent++;
      end
    end
    check("random_samples_sent", sent, 4000);
    check("random_windows_received", rx_cnt - base_rx, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
